dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 55 +++++
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the core port, the debug/loader port and the data-memory command
// port of the data-memory arbiter.
//   core_*  : core load/store request, grant/stall and read return
//   dbg_*   : debug/loader request, grant and read return
//   mem_*   : single-ported synchronous data memory command and read data
// Modports:
//   slave  : the arbiter side (takes requests, drives grants and mem command)
//   master : the environment side (requesters plus memory)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [8:0]        core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_stall;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [8:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_wr;
  logic              mem_rd;
  logic [8:0]        mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_wr, mem_rd, mem_addr, mem_wr_data,
    input  mem_rd_data
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_wr, mem_rd, mem_addr, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-requester arbiter (core, debug/loader) in front of a synchronous data
// memory with one-cycle read latency.
//   clk   : single clock, all state on posedge
//   reset : asynchronous, active-high
//   bus   : dmem_arbiter_if.slave (core_*, dbg_*, mem_* signals)
// Grants are combinational from the requests and registered arbitration state;
// read data is routed back to the port that issued the read one cycle later.
// Build option:
//   DMEM_ARB_RR_EN defined   -> round-robin on contention
//   DMEM_ARB_RR_EN undefined -> core has fixed priority on contention
// In both modes a requester that has held the memory for MAX_BURST consecutive
// grants yields the next contended cycle. MAX_BURST must be in 1..7 (3-bit run
// counter).
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input logic            clk,
  input logic            reset,
  dmem_arbiter_if.slave  bus
);

  localparam logic [2:0] BURST_LIM = 3'(MAX_BURST);
  localparam logic [2:0] CNT_MAX   = 3'd7;

  logic       core_win_s;
  logic       dbg_win_s;
  logic       burst_hit_s;
  logic       rd_issue_s;
  logic       last_dbg_r;   // 1 = dbg was granted most recently
  logic [2:0] run_cnt_r;    // consecutive grants to last owner, saturating
  logic       pend_r;       // a read was granted last cycle
  logic       pend_dbg_r;   // that read belongs to dbg

  // Arbitration: pick at most one winner; nothing is granted while in reset.
  always_comb begin
    core_win_s  = 1'b0;
    dbg_win_s   = 1'b0;
    burst_hit_s = (run_cnt_r >= BURST_LIM);
    if (reset) begin
      core_win_s = 1'b0;
      dbg_win_s  = 1'b0;
    end else if (bus.core_req && bus.dbg_req) begin
      if (burst_hit_s) begin
        // owner exhausted its burst: hand over to the other requester
        core_win_s = last_dbg_r;
        dbg_win_s  = ~last_dbg_r;
      end else begin
`ifdef DMEM_ARB_RR_EN
        core_win_s = last_dbg_r;
        dbg_win_s  = ~last_dbg_r;
`else
        core_win_s = 1'b1;
        dbg_win_s  = 1'b0;
`endif
      end
    end else if (bus.core_req) begin
      core_win_s = 1'b1;
    end else if (bus.dbg_req) begin
      dbg_win_s = 1'b1;
    end else begin
      core_win_s = 1'b0;
      dbg_win_s  = 1'b0;
    end
  end

  // Grant outputs and memory command mux driven by the winner.
  always_comb begin
    bus.core_gnt    = core_win_s;
    bus.dbg_gnt     = dbg_win_s;
    bus.core_stall  = bus.core_req & ~core_win_s & ~reset;
    bus.mem_wr      = 1'b0;
    bus.mem_rd      = 1'b0;
    bus.mem_addr    = 9'd0;
    bus.mem_wr_data = {DATA_W{1'b0}};
    case ({core_win_s, dbg_win_s})
      2'b10: begin
        bus.mem_wr      = bus.core_we;
        bus.mem_rd      = ~bus.core_we;
        bus.mem_addr    = bus.core_addr;
        bus.mem_wr_data = bus.core_wdata;
      end
      2'b01: begin
        bus.mem_wr      = bus.dbg_we;
        bus.mem_rd      = ~bus.dbg_we;
        bus.mem_addr    = bus.dbg_addr;
        bus.mem_wr_data = bus.dbg_wdata;
      end
      default: begin
        bus.mem_wr      = 1'b0;
        bus.mem_rd      = 1'b0;
        bus.mem_addr    = 9'd0;
        bus.mem_wr_data = {DATA_W{1'b0}};
      end
    endcase
    rd_issue_s = bus.mem_rd;
  end

  // Arbitration state: last owner and saturating run counter (held when idle).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_dbg_r <= 1'b0;
      run_cnt_r  <= 3'd0;
    end else if (core_win_s || dbg_win_s) begin
      if (dbg_win_s == last_dbg_r) begin
        run_cnt_r <= (run_cnt_r == CNT_MAX) ? CNT_MAX : run_cnt_r + 3'd1;
      end else begin
        run_cnt_r <= 3'd1;
      end
      last_dbg_r <= dbg_win_s;
    end else begin
      last_dbg_r <= last_dbg_r;
      run_cnt_r  <= run_cnt_r;
    end
  end

  // Read-return tracking: tag every granted read with its owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_r     <= 1'b0;
      pend_dbg_r <= 1'b0;
    end else begin
      pend_r     <= rd_issue_s;
      pend_dbg_r <= dbg_win_s;
    end
  end

  // Route memory read data to the tagged port; rdata is zero when not valid.
  always_comb begin
    bus.core_rvalid = pend_r & ~pend_dbg_r;
    bus.dbg_rvalid  = pend_r & pend_dbg_r;
    if (bus.core_rvalid) begin
      bus.core_rdata = bus.mem_rd_data;
    end else begin
      bus.core_rdata = {DATA_W{1'b0}};
    end
    if (bus.dbg_rvalid) begin
      bus.dbg_rdata = bus.mem_rd_data;
    end else begin
      bus.dbg_rdata = {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed self-checking bench for dmem_arbiter (DATA_W=32, MAX_BURST=4).
// The memory is a read-only synchronous model whose contents are a fixed
// function of the address. Inputs change just after the falling edge and
// outputs are sampled 1 time unit later, away from the rising edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  dmem_arbiter_if #(.DATA_W(32)) bus ();

  dmem_arbiter #(.DATA_W(32), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory contents used by the directed tests
  function automatic logic [31:0] rom(input logic [8:0] a);
    case (a)
      9'h010:  rom = 32'hDEADBEEF;
      9'h001:  rom = 32'hC0C00001;
      9'h002:  rom = 32'hD0D00002;
      9'h003:  rom = 32'h00000003;
      9'h004:  rom = 32'h00000004;
      default: rom = {23'd0, a};
    endcase
  endfunction

  // synchronous memory: data valid the cycle after mem_rd
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rd_data <= rom(bus.mem_addr);
  end

  task automatic drive(input logic cr, input logic cw, input logic [8:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [8:0] da, input logic [31:0] dd);
    @(negedge clk);
    bus.core_req = cr; bus.core_we = cw; bus.core_addr = ca; bus.core_wdata = cd;
    bus.dbg_req  = dr; bus.dbg_we  = dw; bus.dbg_addr  = da; bus.dbg_wdata  = dd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.core_req = 1'b0; bus.dbg_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 9'h010;
    bus.dbg_req  = 1'b1; bus.dbg_we  = 1'b1; bus.dbg_addr  = 9'h002; bus.dbg_wdata = 32'hFFFF0000;
    @(posedge clk);
    #1;
    total++; if (bus.core_gnt !== 1'b0) begin bad++; $display("FAIL rst_core_gnt act=%b exp=0", bus.core_gnt); end
    total++; if (bus.dbg_gnt !== 1'b0) begin bad++; $display("FAIL rst_dbg_gnt act=%b exp=0", bus.dbg_gnt); end
    total++; if (bus.core_stall !== 1'b0) begin bad++; $display("FAIL rst_stall act=%b exp=0", bus.core_stall); end
    total++; if ({bus.mem_wr, bus.mem_rd} !== 2'b00) begin bad++; $display("FAIL rst_mem_cmd act=%b exp=00", {bus.mem_wr, bus.mem_rd}); end
    total++; if (bus.mem_addr !== 9'd0) begin bad++; $display("FAIL rst_mem_addr act=%h exp=000", bus.mem_addr); end
    total++; if (bus.mem_wr_data !== 32'd0) begin bad++; $display("FAIL rst_mem_wdata act=%h exp=0", bus.mem_wr_data); end
    total++; if ({bus.core_rvalid, bus.dbg_rvalid} !== 2'b00) begin bad++; $display("FAIL rst_rvalid act=%b exp=00", {bus.core_rvalid, bus.dbg_rvalid}); end
    total++; if ((bus.core_rdata | bus.dbg_rdata) !== 32'd0) begin bad++; $display("FAIL rst_rdata act=%h exp=0", bus.core_rdata | bus.dbg_rdata); end
    bus.core_req = 1'b0; bus.dbg_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    drive(1'b1, 1'b0, 9'h010, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
    total++; if (bus.core_gnt !== 1'b1) begin bad++; $display("FAIL rd_gnt act=%b exp=1", bus.core_gnt); end
    total++; if (bus.mem_rd !== 1'b1) begin bad++; $display("FAIL rd_mem_rd act=%b exp=1", bus.mem_rd); end
    total++; if (bus.mem_addr !== 9'h010) begin bad++; $display("FAIL rd_addr act=%h exp=010", bus.mem_addr); end
    total++; if (bus.core_stall !== 1'b0) begin bad++; $display("FAIL rd_stall act=%b exp=0", bus.core_stall); end
    idle();
    total++; if (bus.core_rvalid !== 1'b1) begin bad++; $display("FAIL rd_rvalid act=%b exp=1", bus.core_rvalid); end
    total++; if (bus.core_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata act=%h exp=deadbeef", bus.core_rdata); end
    total++; if (bus.dbg_rvalid !== 1'b0) begin bad++; $display("FAIL rd_dbg_rvalid act=%b exp=0", bus.dbg_rvalid); end
    idle();
    total++; if (bus.core_rvalid !== 1'b0) begin bad++; $display("FAIL rd_rvalid_drop act=%b exp=0", bus.core_rvalid); end
  endtask

  task automatic test_dbg_store();
    drive(1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b1, 9'h1FF, 32'h12345678);
    total++; if (bus.dbg_gnt !== 1'b1) begin bad++; $display("FAIL st_gnt act=%b exp=1", bus.dbg_gnt); end
    total++; if ({bus.mem_wr, bus.mem_rd} !== 2'b10) begin bad++; $display("FAIL st_cmd act=%b exp=10", {bus.mem_wr, bus.mem_rd}); end
    total++; if (bus.mem_addr !== 9'h1FF) begin bad++; $display("FAIL st_addr act=%h exp=1ff", bus.mem_addr); end
    total++; if (bus.mem_wr_data !== 32'h12345678) begin bad++; $display("FAIL st_wdata act=%h exp=12345678", bus.mem_wr_data); end
    idle();
    total++; if ({bus.core_rvalid, bus.dbg_rvalid} !== 2'b00) begin bad++; $display("FAIL st_rvalid act=%b exp=00", {bus.core_rvalid, bus.dbg_rvalid}); end
    total++; if (bus.dbg_rdata !== 32'd0) begin bad++; $display("FAIL st_rdata act=%h exp=0", bus.dbg_rdata); end
  endtask

  // both read continuously: core at 1, dbg at 2
  task automatic test_contention();
    logic exp_dbg;
    logic prev_dbg;
    do_reset();
    prev_dbg = 1'b0;
    for (int i = 0; i < 11; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp_dbg = ((i % 2) == 0);
`else
      exp_dbg = ((i % 5) == 4);
`endif
      drive(1'b1, 1'b0, 9'h001, 32'd0, 1'b1, 1'b0, 9'h002, 32'd0);
      total++; if ({bus.core_gnt, bus.dbg_gnt} !== {~exp_dbg, exp_dbg}) begin bad++; $display("FAIL cont_gnt[%0d] act=%b exp=%b", i, {bus.core_gnt, bus.dbg_gnt}, {~exp_dbg, exp_dbg}); end
      total++; if (bus.core_stall !== exp_dbg) begin bad++; $display("FAIL cont_stall[%0d] act=%b exp=%b", i, bus.core_stall, exp_dbg); end
      if (i > 0) begin
        total++; if ({bus.core_rvalid, bus.dbg_rvalid} !== {~prev_dbg, prev_dbg}) begin bad++; $display("FAIL cont_rvalid[%0d] act=%b exp=%b", i, {bus.core_rvalid, bus.dbg_rvalid}, {~prev_dbg, prev_dbg}); end
        total++; if ((bus.core_rdata | bus.dbg_rdata) !== (prev_dbg ? 32'hD0D00002 : 32'hC0C00001)) begin bad++; $display("FAIL cont_rdata[%0d] act=%h exp=%h", i, bus.core_rdata | bus.dbg_rdata, prev_dbg ? 32'hD0D00002 : 32'hC0C00001); end
      end
      prev_dbg = exp_dbg;
    end
    idle();
  endtask

  // core alone four times, idle (counter held), then contention
  task automatic test_burst_hold();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 9'h001, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
    idle();
    idle();
    drive(1'b1, 1'b0, 9'h001, 32'd0, 1'b1, 1'b0, 9'h002, 32'd0);
    total++; if ({bus.core_gnt, bus.dbg_gnt} !== 2'b01) begin bad++; $display("FAIL hold_first act=%b exp=01", {bus.core_gnt, bus.dbg_gnt}); end
    drive(1'b1, 1'b0, 9'h001, 32'd0, 1'b1, 1'b0, 9'h002, 32'd0);
    total++; if ({bus.core_gnt, bus.dbg_gnt} !== 2'b10) begin bad++; $display("FAIL hold_second act=%b exp=10", {bus.core_gnt, bus.dbg_gnt}); end
    total++; if (bus.dbg_rdata !== 32'hD0D00002) begin bad++; $display("FAIL hold_rdata act=%h exp=d0d00002", bus.dbg_rdata); end
    idle();
  endtask

  // alternating single reads, no bubbles
  task automatic test_back_to_back();
    logic use_dbg;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      use_dbg = ((i % 2) == 1);
      if (i < 4) drive(~use_dbg, 1'b0, 9'h003, 32'd0, use_dbg, 1'b0, 9'h004, 32'd0);
      else idle();
      if (i > 0) begin
        total++; if ({bus.core_rvalid, bus.dbg_rvalid} !== {use_dbg, ~use_dbg}) begin bad++; $display("FAIL b2b_rvalid[%0d] act=%b exp=%b", i, {bus.core_rvalid, bus.dbg_rvalid}, {use_dbg, ~use_dbg}); end
        total++; if ({bus.core_rdata, bus.dbg_rdata} !== (use_dbg ? {32'h3, 32'h0} : {32'h0, 32'h4})) begin bad++; $display("FAIL b2b_rdata[%0d] act=%h_%h", i, bus.core_rdata, bus.dbg_rdata); end
      end
    end
  endtask

  task automatic test_reset_cancel();
    do_reset();
    drive(1'b1, 1'b0, 9'h010, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0);
    total++; if (bus.core_gnt !== 1'b1) begin bad++; $display("FAIL rc_gnt act=%b exp=1", bus.core_gnt); end
    reset = 1'b1;
    #1;
    total++; if ({bus.core_gnt, bus.mem_rd, bus.core_stall} !== 3'b000) begin bad++; $display("FAIL rc_in_reset act=%b exp=000", {bus.core_gnt, bus.mem_rd, bus.core_stall}); end
    @(negedge clk);
    reset = 1'b0;
    bus.core_req = 1'b0;
    #1;
    total++; if (bus.core_rvalid !== 1'b0) begin bad++; $display("FAIL rc_rvalid act=%b exp=0", bus.core_rvalid); end
    idle();
    total++; if ({bus.core_rvalid, bus.dbg_rvalid} !== 2'b00) begin bad++; $display("FAIL rc_rvalid2 act=%b exp=00", {bus.core_rvalid, bus.dbg_rvalid}); end
  endtask

  // loser of a contended cycle withdraws: nothing replayed
  task automatic test_drop();
    logic win_dbg;
`ifdef DMEM_ARB_RR_EN
    win_dbg = 1'b1;
`else
    win_dbg = 1'b0;
`endif
    do_reset();
    drive(1'b1, 1'b0, 9'h001, 32'd0, 1'b1, 1'b0, 9'h002, 32'd0);
    total++; if ({bus.core_gnt, bus.dbg_gnt} !== {~win_dbg, win_dbg}) begin bad++; $display("FAIL drop_gnt act=%b exp=%b", {bus.core_gnt, bus.dbg_gnt}, {~win_dbg, win_dbg}); end
    idle();
    total++; if ({bus.core_rvalid, bus.dbg_rvalid} !== {~win_dbg, win_dbg}) begin bad++; $display("FAIL drop_rvalid act=%b exp=%b", {bus.core_rvalid, bus.dbg_rvalid}, {~win_dbg, win_dbg}); end
    total++; if (bus.mem_rd !== 1'b0) begin bad++; $display("FAIL drop_replay act=%b exp=0", bus.mem_rd); end
    idle();
    total++; if ({bus.core_rvalid, bus.dbg_rvalid} !== 2'b00) begin bad++; $display("FAIL drop_late act=%b exp=00", {bus.core_rvalid, bus.dbg_rvalid}); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = 9'd0; bus.core_wdata = 32'd0;
    bus.dbg_req  = 1'b0; bus.dbg_we  = 1'b0; bus.dbg_addr  = 9'd0; bus.dbg_wdata  = 32'd0;
    bus.mem_rd_data = 32'd0;
    test_reset();
    test_single_read();
    test_dbg_store();
    test_contention();
    test_burst_hold();
    test_back_to_back();
    test_reset_cancel();
    test_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
